timer_ctrl_master: RTL and testbench

- Avalon-MM initiator that programs and services the 16-bit interval-timer slave (3-bit word address, registered readdata, no waitrequest) on behalf of hardware clients, with no soft-core involvement.
- Accepts high-level commands (set period, start, stop, snapshot, read or clear status) and expands them into register write/read sequences.
- Optionally auto-acknowledges the timer irq and counts timeouts.
- Sits between a hardware sequencer and the timer's s1 port.

---
 rtl/timer_ctrl_pkg.sv | 40 ++++
 rtl/timer_ctrl_master.sv | 157 +++++++++++++++
 tb/tb_timer_ctrl_master.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the interval-timer command master: opcodes,
// timer register map, control bit positions and FSM states.
package timer_ctrl_pkg;

  localparam logic [2:0] OP_SET_PERIOD = 3'd0;
  localparam logic [2:0] OP_START      = 3'd1;
  localparam logic [2:0] OP_STOP       = 3'd2;
  localparam logic [2:0] OP_SNAPSHOT   = 3'd3;
  localparam logic [2:0] OP_RD_STATUS  = 3'd4;
  localparam logic [2:0] OP_CLR_STATUS = 3'd5;

  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERIODL = 3'd2;
  localparam logic [2:0] REG_PERIODH = 3'd3;
  localparam logic [2:0] REG_SNAPL   = 3'd4;
  localparam logic [2:0] REG_SNAPH   = 3'd5;

  localparam int unsigned CTRL_ITO   = 0;
  localparam int unsigned CTRL_CONT  = 1;
  localparam int unsigned CTRL_START = 2;
  localparam int unsigned CTRL_STOP  = 3;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_PLO   = 4'd1,
    WR_PHI   = 4'd2,
    WR_CTRL  = 4'd3,
    WR_SNAP  = 4'd4,
    RD_SLO   = 4'd5,
    RD_SHI   = 4'd6,
    RD_CAP   = 4'd7,
    RD_STAT  = 4'd8,
    STAT_CAP = 4'd9,
    WR_STAT  = 4'd10,
    ACK_IRQ  = 4'd11,
    RESP     = 4'd12
  } state_t;

endpackage

// File: rtl/timer_ctrl_master.sv
// Avalon-MM initiator that expands high-level timer commands into register
// access sequences on the interval timer's s1 port and services its irq.
module timer_ctrl_master
  import timer_ctrl_pkg::*;
#(
  parameter int AUTO_ACK = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [31:0]      cmd_period,
  input  logic [1:0]       cmd_ctrl,
  output logic             rsp_valid,
  output logic [31:0]      rsp_data,
  output logic             rsp_err,
  output logic [2:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [15:0]      avm_writedata,
  input  logic [15:0]      avm_readdata,
  input  logic             irq_in,
  output logic [CNT_W-1:0] timeout_count,
  output logic             busy
);

  localparam logic ACK_EN = (AUTO_ACK != 0);

  state_t      state, state_nxt;
  logic [15:0] period_hi;
  logic [15:0] snap_lo;
  logic        irq_svc;
  logic        cmd_fire;
  logic        cs_nxt;
  logic        wr_n_nxt;
  logic [2:0]  addr_nxt;
  logic [15:0] wdata_nxt;

  assign irq_svc   = ACK_EN & irq_in;
  assign cmd_ready = ~reset & (state == IDLE) & ~irq_svc;
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (irq_svc) begin
          state_nxt = ACK_IRQ;
        end else if (cmd_fire) begin
          case (cmd_op)
            OP_SET_PERIOD:     state_nxt = WR_PLO;
            OP_START, OP_STOP: state_nxt = WR_CTRL;
            OP_SNAPSHOT:       state_nxt = WR_SNAP;
            OP_RD_STATUS:      state_nxt = RD_STAT;
            OP_CLR_STATUS:     state_nxt = WR_STAT;
            default:           state_nxt = RESP;
          endcase
        end
      end
      WR_PLO:   state_nxt = WR_PHI;
      WR_PHI:   state_nxt = RESP;
      WR_CTRL:  state_nxt = RESP;
      WR_SNAP:  state_nxt = RD_SLO;
      RD_SLO:   state_nxt = RD_SHI;
      RD_SHI:   state_nxt = RD_CAP;
      RD_CAP:   state_nxt = RESP;
      RD_STAT:  state_nxt = STAT_CAP;
      STAT_CAP: state_nxt = RESP;
      WR_STAT:  state_nxt = RESP;
      ACK_IRQ:  state_nxt = IDLE;
      RESP:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Bus outputs are derived from the next state so the registered avm_*
  // signals line up with the state that owns the access.
  always_comb begin
    cs_nxt    = 1'b0;
    wr_n_nxt  = 1'b1;
    addr_nxt  = avm_address;
    wdata_nxt = avm_writedata;
    case (state_nxt)
      WR_PLO: begin
        cs_nxt = 1'b1; wr_n_nxt = 1'b0;
        addr_nxt = REG_PERIODL; wdata_nxt = cmd_period[15:0];
      end
      WR_PHI: begin
        cs_nxt = 1'b1; wr_n_nxt = 1'b0;
        addr_nxt = REG_PERIODH; wdata_nxt = period_hi;
      end
      WR_CTRL: begin
        cs_nxt = 1'b1; wr_n_nxt = 1'b0;
        addr_nxt = REG_CONTROL; wdata_nxt = '0;
        if (cmd_op == OP_START) begin
          wdata_nxt[CTRL_START] = 1'b1;
          wdata_nxt[CTRL_CONT]  = cmd_ctrl[1];
          wdata_nxt[CTRL_ITO]   = cmd_ctrl[0];
        end else begin
          wdata_nxt[CTRL_STOP] = 1'b1;
        end
      end
      WR_SNAP: begin
        cs_nxt = 1'b1; wr_n_nxt = 1'b0;
        addr_nxt = REG_SNAPL; wdata_nxt = '0;
      end
      RD_SLO:  begin cs_nxt = 1'b1; addr_nxt = REG_SNAPL;  end
      RD_SHI:  begin cs_nxt = 1'b1; addr_nxt = REG_SNAPH;  end
      RD_STAT: begin cs_nxt = 1'b1; addr_nxt = REG_STATUS; end
      WR_STAT, ACK_IRQ: begin
        cs_nxt = 1'b1; wr_n_nxt = 1'b0;
        addr_nxt = REG_STATUS; wdata_nxt = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= '0;
      avm_writedata  <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_err        <= 1'b0;
      timeout_count  <= '0;
      period_hi      <= '0;
      snap_lo        <= '0;
    end else begin
      state          <= state_nxt;
      avm_chipselect <= cs_nxt;
      avm_write_n    <= wr_n_nxt;
      avm_address    <= addr_nxt;
      avm_writedata  <= wdata_nxt;
      if (cmd_fire) period_hi <= cmd_period[31:16];
      if (state == RD_SHI) snap_lo <= avm_readdata;
      rsp_valid <= (state_nxt == RESP);
      // Only an illegal opcode reaches RESP straight from IDLE.
      if (state_nxt == RESP) begin
        rsp_err <= (state == IDLE);
        case (state)
          RD_CAP:   rsp_data <= {avm_readdata, snap_lo};
          STAT_CAP: rsp_data <= {30'b0, avm_readdata[1:0]};
          default:  rsp_data <= '0;
        endcase
      end
      if ((state == ACK_IRQ) && (timeout_count != '1))
        timeout_count <= timeout_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Bench for timer_ctrl_master: a behavioural interval-timer slave plus
// directed and randomized command sequences checked against per-op bus scripts.
module tb_timer_ctrl_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = '0;
  logic [31:0] cmd_period = '0;
  logic [1:0]  cmd_ctrl = '0;
  logic        cmd_ready, rsp_valid, rsp_err, avm_chipselect, avm_write_n, irq_in, busy;
  logic [31:0] rsp_data;
  logic [2:0]  avm_address;
  logic [15:0] avm_writedata, avm_readdata, timeout_count;

  logic        irq2 = 1'b0;
  logic        cmd_ready2, rsp_valid2, rsp_err2, cs2, wn2, busy2;
  logic [31:0] rsp_data2;
  logic [2:0]  addr2, tc2;
  logic [15:0] wd2;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_rsp;

  always #5 clk = ~clk;

  timer_ctrl_master #(.AUTO_ACK(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_period(cmd_period), .cmd_ctrl(cmd_ctrl),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .irq_in(irq_in),
    .timeout_count(timeout_count), .busy(busy)
  );

  timer_ctrl_master #(.AUTO_ACK(1), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .cmd_valid(1'b0), .cmd_ready(cmd_ready2),
    .cmd_op(3'd0), .cmd_period(32'd0), .cmd_ctrl(2'd0),
    .rsp_valid(rsp_valid2), .rsp_data(rsp_data2), .rsp_err(rsp_err2),
    .avm_address(addr2), .avm_chipselect(cs2), .avm_write_n(wn2),
    .avm_writedata(wd2), .avm_readdata(16'h0000), .irq_in(irq2),
    .timeout_count(tc2), .busy(busy2)
  );

  // Behavioural interval timer (s1 slave)
  logic [31:0] t_period, t_cnt, t_snap;
  logic        t_run, t_to, t_ito, t_cont;
  logic [15:0] t_rd;
  assign avm_readdata = t_rd;
  assign irq_in = t_to & t_ito;

  always @(posedge clk) begin
    if (reset) begin
      t_period <= '0; t_cnt <= '0; t_snap <= '0; t_rd <= '0;
      t_run <= 1'b0; t_to <= 1'b0; t_ito <= 1'b0; t_cont <= 1'b0;
    end else begin
      if (t_run) begin
        if (t_cnt == 0) begin
          t_to <= 1'b1; t_cnt <= t_period;
          if (!t_cont) t_run <= 1'b0;
        end else begin
          t_cnt <= t_cnt - 1;
        end
      end
      if (avm_chipselect && !avm_write_n) begin
        case (avm_address)
          3'd0: t_to <= 1'b0;
          3'd1: begin
            t_ito <= avm_writedata[0]; t_cont <= avm_writedata[1];
            if (avm_writedata[2]) t_run <= 1'b1;
            if (avm_writedata[3]) t_run <= 1'b0;
          end
          3'd2: begin
            t_period[15:0] <= avm_writedata;
            t_cnt <= {t_period[31:16], avm_writedata}; t_run <= 1'b0;
          end
          3'd3: begin
            t_period[31:16] <= avm_writedata;
            t_cnt <= {avm_writedata, t_period[15:0]}; t_run <= 1'b0;
          end
          3'd4, 3'd5: t_snap <= t_cnt;
          default: ;
        endcase
      end else if (avm_chipselect) begin
        case (avm_address)
          3'd0: t_rd <= {14'b0, t_run, t_to};
          3'd2: t_rd <= t_period[15:0];
          3'd3: t_rd <= t_period[31:16];
          3'd4: t_rd <= t_snap[15:0];
          3'd5: t_rd <= t_snap[31:16];
          default: t_rd <= '0;
        endcase
      end
    end
  end

  typedef struct packed {
    logic        cs;
    logic        wn;
    logic [2:0]  a;
    logic [15:0] d;
    logic        rv;
  } bus_t;

  function automatic bus_t bw(input logic [2:0] a, input logic [15:0] d);
    return '{cs: 1'b1, wn: 1'b0, a: a, d: d, rv: 1'b0};
  endfunction
  function automatic bus_t br(input logic [2:0] a);
    return '{cs: 1'b1, wn: 1'b1, a: a, d: 16'h0, rv: 1'b0};
  endfunction
  function automatic bus_t bq(input logic rv);
    return '{cs: 1'b0, wn: 1'b1, a: 3'd0, d: 16'h0, rv: rv};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of the accept cycle with the command already driven.
  task automatic run_window(input logic [2:0] op, input logic [31:0] per, input logic [1:0] ctl);
    bus_t q[$];
    logic [31:0] exp_data = '0;
    case (op)
      3'd0: begin q.push_back(bw(3'd2, per[15:0])); q.push_back(bw(3'd3, per[31:16])); end
      3'd1: q.push_back(bw(3'd1, {12'h0, 2'b01, ctl[1], ctl[0]}));
      3'd2: q.push_back(bw(3'd1, 16'h0008));
      3'd3: begin
        q.push_back(bw(3'd4, 16'h0)); q.push_back(br(3'd4));
        q.push_back(br(3'd5)); q.push_back(bq(1'b0));
      end
      3'd4: begin q.push_back(br(3'd0)); q.push_back(bq(1'b0)); end
      3'd5: q.push_back(bw(3'd0, 16'h0));
      default: ;
    endcase
    q.push_back(bq(1'b1));
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    foreach (q[i]) begin
      if (i == 0) begin
        if (op == 3'd3) exp_data = t_cnt;
        else if (op == 3'd4) exp_data = {30'b0, t_run, t_to};
      end
      chk($sformatf("op%0d_c%0d_cs", op, i + 1), avm_chipselect, q[i].cs);
      chk($sformatf("op%0d_c%0d_wn", op, i + 1), avm_write_n, q[i].wn);
      if (q[i].cs) chk($sformatf("op%0d_c%0d_addr", op, i + 1), avm_address, q[i].a);
      if (q[i].cs && !q[i].wn) chk($sformatf("op%0d_c%0d_wdata", op, i + 1), avm_writedata, q[i].d);
      chk($sformatf("op%0d_c%0d_rsp_valid", op, i + 1), rsp_valid, q[i].rv);
      chk($sformatf("op%0d_c%0d_busy", op, i + 1), busy, 1'b1);
      if (q[i].rv) begin
        chk($sformatf("op%0d_rsp_data", op), rsp_data, exp_data);
        chk($sformatf("op%0d_rsp_err", op), rsp_err, (op > 3'd5));
        last_rsp = rsp_data;
      end
      @(negedge clk);
    end
    chk($sformatf("op%0d_rsp_pulse_end", op), rsp_valid, 1'b0);
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [31:0] per, input logic [1:0] ctl);
    int unsigned w = 0;
    while (!cmd_ready && w < 64) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_ready_wait", cmd_ready, 1'b1);
    if (!cmd_ready) return;
    cmd_valid = 1'b1; cmd_op = op; cmd_period = per; cmd_ctrl = ctl;
    run_window(op, per, ctl);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] rper;
    logic [1:0]  rctl;
    int unsigned w;

    repeat (3) @(negedge clk);
    chk("rst_cs", avm_chipselect, 1'b0);
    chk("rst_wn", avm_write_n, 1'b1);
    chk("rst_addr", avm_address, 3'd0);
    chk("rst_wdata", avm_writedata, 16'h0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_timeout_count", timeout_count, 16'h0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);

    // Saturation on a narrow counter instance
    irq2 = 1'b1;
    @(negedge clk);
    chk("sat_ack_cs", cs2, 1'b1);
    chk("sat_ack_wn", wn2, 1'b0);
    chk("sat_ack_addr", addr2, 3'd0);
    @(negedge clk);
    chk("sat_count_first", tc2, 3'd1);
    repeat (30) @(negedge clk);
    chk("sat_count_full", tc2, 3'd7);
    irq2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("sat_count_hold", tc2, 3'd7);
    chk("sat_idle", busy2, 1'b0);

    do_cmd(3'd0, 32'h0001_86A0, 2'b00);
    chk("slave_cnt_loaded", t_cnt, 32'h0001_86A0);
    do_cmd(3'd1, 32'h0, 2'b11);
    chk("slave_run", t_run, 1'b1);
    do_cmd(3'd4, 32'h0, 2'b00);
    chk("rd_status_run", last_rsp, 32'h2);
    repeat (100) @(negedge clk);
    do_cmd(3'd3, 32'h0, 2'b00);
    do_cmd(3'd2, 32'h0, 2'b00);
    chk("slave_stopped", t_run, 1'b0);
    do_cmd(3'd7, 32'h0, 2'b00);
    do_cmd(3'd5, 32'h0, 2'b00);

    // Irq service with a colliding command
    do_cmd(3'd0, 32'd30, 2'b00);
    do_cmd(3'd1, 32'h0, 2'b01);
    chk("irq_count_before", timeout_count, 16'd0);
    w = 0;
    while (!irq_in && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("irq_rise", irq_in, 1'b1);
    chk("irq_blocks_ready", cmd_ready, 1'b0);
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_period = '0; cmd_ctrl = '0;
    @(negedge clk);
    chk("ack_cs", avm_chipselect, 1'b1);
    chk("ack_wn", avm_write_n, 1'b0);
    chk("ack_addr", avm_address, 3'd0);
    chk("ack_cmd_waits", cmd_ready, 1'b0);
    chk("ack_no_rsp", rsp_valid, 1'b0);
    @(negedge clk);
    chk("irq_cleared", irq_in, 1'b0);
    chk("irq_count_after", timeout_count, 16'd1);
    chk("cmd_ready_after_ack", cmd_ready, 1'b1);
    run_window(3'd4, 32'h0, 2'b00);

    // Reset in the middle of a snapshot
    cmd_valid = 1'b1; cmd_op = 3'd3;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_cs", avm_chipselect, 1'b0);
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_cmd_ready", cmd_ready, 1'b1);
    chk("midrst_count_clear", timeout_count, 16'd0);
    w = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) w++;
      @(negedge clk);
    end
    chk("midrst_no_rsp", w, 0);

    // Randomized command stream without irq enable
    for (int n = 0; n < 40; n++) begin
      rop  = 3'($urandom_range(0, 7));
      rper = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(8, 400));
      rctl = {1'($urandom_range(0, 1)), 1'b0};
      do_cmd(rop, rper, rctl);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    chk("final_count", timeout_count, 16'd0);
    chk("final_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
